// File: rtl/local_velocity_scheduler_pkg.sv
// Shared types and constants for the local-velocity multiplier sequencer.
// Results are signed-magnitude Q(32,15).
package local_velocity_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    ISSUE,
    WAIT,
    STORE,
    DONE
  } state_t;

  localparam logic [1:0] IDX_VX = 2'd0;
  localparam logic [1:0] IDX_VY = 2'd1;
  localparam logic [1:0] IDX_WZ = 2'd2;

  localparam int FRACTIONAL_Q = 15;

  // r/4 for the linear terms, r/(4(lx+ly)) for the yaw term
  localparam logic [31:0] K_V_DEFAULT = 32'h0000_0129;
  localparam logic [31:0] K_W_DEFAULT = 32'h0000_0708;

endpackage

// File: rtl/local_velocity_scheduler_period_tick_gen.sv
// Free-running sample-period counter; tick is high while the count sits at its last value.
// Enable low holds the count at 0, so re-enabling always starts a full period.
module period_tick_gen #(
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/local_velocity_scheduler.sv
// Time-shares one serial multiplier over vx/vy/wz each period; Valid 3M+9 cycles after tick.
// Ticks arriving while busy are dropped (sticky Overrun). LOCAL_VELOCITY_SCHED_TIMEOUT_EN adds a WAIT watchdog.
module local_velocity_scheduler
  import local_velocity_scheduler_pkg::*;
#(
  parameter int DATAWIDTH_N   = 32,
  parameter int PERIOD_CYCLES = 50000,
`ifdef LOCAL_VELOCITY_SCHED_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 255,
`endif
  parameter logic [DATAWIDTH_N-1:0] K_V = DATAWIDTH_N'(K_V_DEFAULT),
  parameter logic [DATAWIDTH_N-1:0] K_W = DATAWIDTH_N'(K_W_DEFAULT)
) (
  input  logic                   LOCAL_VELOCITY_SCHED_CLOCK_50,
  input  logic                   LOCAL_VELOCITY_SCHED_Reset_InLow,
  input  logic [DATAWIDTH_N-1:0] SUMX_InBus,
  input  logic [DATAWIDTH_N-1:0] SUMY_InBus,
  input  logic [DATAWIDTH_N-1:0] SUMZ_InBus,
  input  logic                   Enable_InHigh,
  output logic [DATAWIDTH_N-1:0] MultA_OutBus,
  output logic [DATAWIDTH_N-1:0] MultB_OutBus,
  output logic                   MultStart_Out,
  input  logic [DATAWIDTH_N-1:0] MultResult_InBus,
  input  logic                   MultComplete_InHigh,
  output logic [DATAWIDTH_N-1:0] VX_OutBus,
  output logic [DATAWIDTH_N-1:0] VY_OutBus,
  output logic [DATAWIDTH_N-1:0] WZ_OutBus,
  output logic                   Valid_OutHigh,
  output logic                   Busy_OutHigh,
  output logic                   Overrun_OutHigh,
  output logic                   Timeout_OutHigh
);

  state_t                   state;
  logic [1:0]               k;
  logic                     tick;
  logic                     complete_d;
  logic [DATAWIDTH_N-1:0]   snap   [3];
  logic [DATAWIDTH_N-1:0]   shadow [3];

  wire complete_rise = MultComplete_InHigh && !complete_d;

`ifdef LOCAL_VELOCITY_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd;
`else
  assign Timeout_OutHigh = 1'b0;
`endif

  period_tick_gen #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_tick (
    .clk    (LOCAL_VELOCITY_SCHED_CLOCK_50),
    .rst_n  (LOCAL_VELOCITY_SCHED_Reset_InLow),
    .enable (Enable_InHigh),
    .tick   (tick)
  );

  always_ff @(posedge LOCAL_VELOCITY_SCHED_CLOCK_50 or negedge LOCAL_VELOCITY_SCHED_Reset_InLow) begin
    if (!LOCAL_VELOCITY_SCHED_Reset_InLow) begin
      state           <= IDLE;
      k               <= IDX_VX;
      complete_d      <= 1'b0;
      MultA_OutBus    <= '0;
      MultB_OutBus    <= '0;
      MultStart_Out   <= 1'b0;
      VX_OutBus       <= '0;
      VY_OutBus       <= '0;
      WZ_OutBus       <= '0;
      Valid_OutHigh   <= 1'b0;
      Busy_OutHigh    <= 1'b0;
      Overrun_OutHigh <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        snap[i]   <= '0;
        shadow[i] <= '0;
      end
`ifdef LOCAL_VELOCITY_SCHED_TIMEOUT_EN
      wd              <= '0;
      Timeout_OutHigh <= 1'b0;
`endif
    end else begin
      MultStart_Out <= 1'b0;
      Valid_OutHigh <= 1'b0;
      complete_d    <= MultComplete_InHigh;
      if (tick && state != IDLE) Overrun_OutHigh <= 1'b1;

      case (state)
        IDLE: begin
          // Busy stays up through the Valid cycle and drops here unless a new period starts.
          Busy_OutHigh <= tick;
          if (tick) state <= CAPTURE;
        end
        CAPTURE: begin
          snap[IDX_VX]  <= SUMX_InBus;
          snap[IDX_VY]  <= SUMY_InBus;
          snap[IDX_WZ]  <= SUMZ_InBus;
          k             <= IDX_VX;
          MultA_OutBus  <= SUMX_InBus;
          MultB_OutBus  <= K_V;
          MultStart_Out <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
`ifdef LOCAL_VELOCITY_SCHED_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        WAIT: begin
          // Only a fresh edge counts; a level held over from the last product is stale.
          if (complete_rise) state <= STORE;
`ifdef LOCAL_VELOCITY_SCHED_TIMEOUT_EN
          else if (wd == WD_LAST) begin
            Timeout_OutHigh <= 1'b1;
            Busy_OutHigh    <= 1'b0;
            state           <= IDLE;
          end else begin
            wd <= wd + WW'(1);
          end
`endif
        end
        STORE: begin
          shadow[k] <= MultResult_InBus;
          if (k == IDX_WZ) begin
            state <= DONE;
          end else begin
            k             <= k + 2'd1;
            MultA_OutBus  <= snap[k + 2'd1];
            MultB_OutBus  <= (k + 2'd1 == IDX_WZ) ? K_W : K_V;
            MultStart_Out <= 1'b1;
            state         <= ISSUE;
          end
        end
        DONE: begin
          VX_OutBus     <= shadow[IDX_VX];
          VY_OutBus     <= shadow[IDX_VY];
          WZ_OutBus     <= shadow[IDX_WZ];
          Valid_OutHigh <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_velocity_scheduler.sv
// Directed bench: two scheduler instances (period 200 and 50) with behavioural serial multipliers.
module tb_local_velocity_scheduler;

`ifdef LOCAL_VELOCITY_SCHED_TIMEOUT_EN
  localparam int M1 = 12;
`else
  localparam int M1 = 33;
`endif
  localparam int M2 = 33;
  localparam int P1 = 200;
  localparam int P2 = 50;
  localparam logic [31:0] KV = 32'h0000_0129;
  localparam logic [31:0] KW = 32'h0000_0708;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n, en1, en2, linger, stall;
  logic [31:0] sumx, sumy, sumz;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] a1, b1, res1, vx1, vy1, wz1;
  logic        start1, cmpl1, valid1, busy1, ovr1, to1;
  logic [31:0] a2, b2, res2, vx2, vy2, wz2;
  logic        start2, cmpl2, valid2, busy2, ovr2, to2;

  local_velocity_scheduler #(
    .DATAWIDTH_N   (32),
    .PERIOD_CYCLES (P1)
`ifdef LOCAL_VELOCITY_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut1 (
    .LOCAL_VELOCITY_SCHED_CLOCK_50    (clk),
    .LOCAL_VELOCITY_SCHED_Reset_InLow (rst_n),
    .SUMX_InBus (sumx), .SUMY_InBus (sumy), .SUMZ_InBus (sumz),
    .Enable_InHigh (en1),
    .MultA_OutBus (a1), .MultB_OutBus (b1), .MultStart_Out (start1),
    .MultResult_InBus (res1), .MultComplete_InHigh (cmpl1),
    .VX_OutBus (vx1), .VY_OutBus (vy1), .WZ_OutBus (wz1),
    .Valid_OutHigh (valid1), .Busy_OutHigh (busy1),
    .Overrun_OutHigh (ovr1), .Timeout_OutHigh (to1)
  );

  local_velocity_scheduler #(
    .DATAWIDTH_N   (32),
    .PERIOD_CYCLES (P2)
  ) dut2 (
    .LOCAL_VELOCITY_SCHED_CLOCK_50    (clk),
    .LOCAL_VELOCITY_SCHED_Reset_InLow (rst_n),
    .SUMX_InBus (sumx), .SUMY_InBus (sumy), .SUMZ_InBus (sumz),
    .Enable_InHigh (en2),
    .MultA_OutBus (a2), .MultB_OutBus (b2), .MultStart_Out (start2),
    .MultResult_InBus (res2), .MultComplete_InHigh (cmpl2),
    .VX_OutBus (vx2), .VY_OutBus (vy2), .WZ_OutBus (wz2),
    .Valid_OutHigh (valid2), .Busy_OutHigh (busy2),
    .Overrun_OutHigh (ovr2), .Timeout_OutHigh (to2)
  );

  // Signed-magnitude Q(32,15) product, truncating.
  function automatic logic [31:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic [61:0] p;
    p = a[30:0] * b[30:0];
    return {a[31] ^ b[31], p[45:15]};
  endfunction

  // Multiplier models: Complete first high M cycles after the start cycle, then held as a level.
  // Linger keeps Complete high for the first WAIT cycles; result is junk until done.
  int          age1 = 0, age2 = 0;
  logic [31:0] prod1 = '0, prod2 = '0;

  always @(posedge clk) begin
    if (start1) begin
      age1  <= 1;
      prod1 <= smul(a1, b1);
    end else if (age1 > 0 && age1 < 1000) age1 <= age1 + 1;
  end
  assign cmpl1 = !stall && ((age1 >= M1) || (linger && age1 < 4));
  assign res1  = (age1 >= M1) ? prod1 : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (start2) begin
      age2  <= 1;
      prod2 <= smul(a2, b2);
    end else if (age2 > 0 && age2 < 1000) age2 <= age2 + 1;
  end
  assign cmpl2 = (age2 >= M2);
  assign res2  = (age2 >= M2) ? prod2 : 32'hDEAD_BEEF;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  // One full sequence on dut1 for a tick at cycle t.
  task automatic run_seq(input int t, input logic [31:0] sx, input logic [31:0] sz,
                         input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez,
                         input logic [31:0] ox, input logic [31:0] oy, input logic [31:0] oz);
    int nval;
    wait_until(t);
    check_val("busy_at_tick", busy1, 1'b0);
    step();
    check_val("busy_after_tick", busy1, 1'b1);
    step();
    check_val("start_k0", start1, 1'b1);
    check_val("multa_k0", a1, sx);
    check_val("multb_k0", b1, KV);
    // Inputs move after capture; the products must still use the snapshot.
    sumx = ~sumx; sumy = ~sumy; sumz = ~sumz;
    wait_until(t + 2 + 2 * (M1 + 2));
    check_val("start_k2", start1, 1'b1);
    check_val("multa_k2", a1, sz);
    check_val("multb_k2", b1, KW);
    nval = 0;
    while (cyc < t + 3 * M1 + 8) begin
      step();
      if (valid1) nval++;
    end
    check_val("no_early_valid", nval, 0);
    check_val("vx_held", vx1, ox);
    check_val("vy_held", vy1, oy);
    check_val("wz_held", wz1, oz);
    step();
    check_val("valid_time", valid1, 1'b1);
    check_val("vx", vx1, ex);
    check_val("vy", vy1, ey);
    check_val("wz", wz1, ez);
    check_val("busy_in_valid", busy1, 1'b1);
    step();
    check_val("valid_one_cycle", valid1, 1'b0);
    check_val("busy_end", busy1, 1'b0);
  endtask

  initial begin
    int t, r, nval;
    rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0; linger = 1'b0; stall = 1'b0;
    sumx = '0; sumy = '0; sumz = '0;
    repeat (3) step();
    check_val("rst_vx", vx1, 0);
    check_val("rst_valid", valid1, 1'b0);
    check_val("rst_busy", busy1, 1'b0);
    check_val("rst_overrun", ovr1, 1'b0);
    check_val("rst_start", start1, 1'b0);
    check_val("rst_multa", a1, 0);
    rst_n = 1'b1;
    step(); step();

    // 1.0, -1.0, 2.0
    sumx = 32'h0000_8000; sumy = 32'h8000_8000; sumz = 32'h0001_0000;
    en1 = 1'b1;
    t = cyc + P1 - 1;
    run_seq(t, 32'h0000_8000, 32'h0001_0000, 32'h0000_0129, 32'h8000_0129, 32'h0000_0E10, 0, 0, 0);
    check_val("no_overrun", ovr1, 1'b0);

    // 2.0, 0.5, -1.0 with Complete lingering high from the previous product
    sumx = 32'h0001_0000; sumy = 32'h0000_4000; sumz = 32'h8000_8000;
    linger = 1'b1;
    t += P1;
    run_seq(t, 32'h0001_0000, 32'h8000_8000, 32'h0000_0252, 32'h0000_0094, 32'h8000_0708,
            32'h0000_0129, 32'h8000_0129, 32'h0000_0E10);
    linger = 1'b0;

`ifdef LOCAL_VELOCITY_SCHED_TIMEOUT_EN
    stall = 1'b1;
    t += P1;
    wait_until(t + 18);
    check_val("timeout_not_yet", to1, 1'b0);
    check_val("busy_in_wait", busy1, 1'b1);
    step();
    check_val("timeout_set", to1, 1'b1);
    check_val("busy_after_abort", busy1, 1'b0);
    nval = 0;
    while (cyc < t + 150) begin
      step();
      if (valid1) nval++;
    end
    check_val("no_valid_on_abort", nval, 0);
    check_val("vx_kept", vx1, 32'h0000_0252);
    check_val("wz_kept", wz1, 32'h8000_0708);
    stall = 1'b0;
    sumx = 32'h0000_8000; sumy = 32'h8000_8000; sumz = 32'h0001_0000;
    t += P1;
    run_seq(t, 32'h0000_8000, 32'h0001_0000, 32'h0000_0129, 32'h8000_0129, 32'h0000_0E10,
            32'h0000_0252, 32'h0000_0094, 32'h8000_0708);
`else
    check_val("timeout_tied_low", to1, 1'b0);
`endif

    // Async reset in the middle of the vy product
    sumx = 32'h0000_C000; sumy = 32'h0000_0000; sumz = 32'h8000_4000;
    t += P1;
    wait_until(t + M1 + 10);
    check_val("busy_before_rst", busy1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_vx", vx1, 0);
    check_val("rst_mid_vy", vy1, 0);
    check_val("rst_mid_wz", wz1, 0);
    check_val("rst_mid_busy", busy1, 1'b0);
    step(); step();
    rst_n = 1'b1;
    r = cyc;
    t = r + P1 - 1;
    nval = 0;
    while (cyc < t) begin
      step();
      if (valid1) nval++;
    end
    check_val("no_valid_after_rst", nval, 0);
    run_seq(t, 32'h0000_C000, 32'h8000_4000, 32'h0000_01BD, 32'h0000_0000, 32'h8000_0384, 0, 0, 0);

    // Period 50 instance: ticks at +50 and +100 land while busy
    sumx = 32'h0000_8000; sumy = 32'h8000_8000; sumz = 32'h0001_0000;
    step();
    en2 = 1'b1;
    t = cyc + P2 - 1;
    wait_until(t + 50);
    check_val("ovr_before", ovr2, 1'b0);
    step();
    check_val("ovr_set", ovr2, 1'b1);
    wait_until(t + 108);
    check_val("ovr_valid1", valid2, 1'b1);
    check_val("ovr_vx1", vx2, 32'h0000_0129);
    check_val("ovr_vy1", vy2, 32'h8000_0129);
    check_val("ovr_wz1", wz2, 32'h0000_0E10);
    sumx = 32'h0001_0000; sumy = 32'h0000_4000; sumz = 32'h8000_8000;
    nval = 0;
    while (cyc < t + 257) begin
      step();
      if (valid2) nval++;
    end
    check_val("ovr_no_extra_valid", nval, 0);
    step();
    check_val("ovr_valid2", valid2, 1'b1);
    check_val("ovr_vx2", vx2, 32'h0000_0252);
    check_val("ovr_vy2", vy2, 32'h0000_0094);
    check_val("ovr_wz2", wz2, 32'h8000_0708);
    check_val("ovr_sticky", ovr2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
